rv_wb_arbiter: RTL and testbench
================================

Name: rv_wb_arbiter

Overview:
Writeback controller for the register file's single write port. Arbitrates round-robin between two writeback requesters: ALU and load/store unit (LSU). Drives a registered write command to the register file. Keeps a per-register busy scoreboard so decode can stall on RAW/WAW hazards until the producing write has landed.

Parameters:
XLEN, 32, data width of write data
REG_AW, 5, register address width
NUM_REGS, 32, number of architectural registers (2**REG_AW)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
alu_valid_i  in  1  ALU writeback request
alu_rd_i  in  REG_AW  ALU destination register
alu_data_i  in  XLEN  ALU result
alu_ready_o  out  1  ALU request accepted this cycle
lsu_valid_i  in  1  LSU writeback request
lsu_rd_i  in  REG_AW  LSU destination register
lsu_data_i  in  XLEN  load data
lsu_ready_o  out  1  LSU request accepted this cycle
issue_valid_i  in  1  decode issues an instruction that writes issue_rd_i
issue_rd_i  in  REG_AW  destination of issuing instruction
rs1_i, rs2_i  in  REG_AW  sources of the instruction in decode
stall_o  out  1  hazard: decode must hold
rf_write_o  out  1  register file write enable
rf_rd_o  out  REG_AW  register file write address
rf_data_o  out  XLEN  register file write data
busy_o  out  NUM_REGS  scoreboard state

Behaviour:
- Reset (async, rst_n=0): rf_write_o=0, rf_rd_o=0, rf_data_o=0, busy_o=0, last_grant=LSU (ALU wins the first tie). ready outputs are combinational and fall to 0 whenever no request is present.
- Handshake: a transfer occurs when valid&&ready in the same cycle. Requesters hold valid, rd and data stable until ready is seen.
- Arbitration (combinational):
  - Only one valid → that requester is granted.
  - Both valid → the requester not in last_grant is granted.
  - Exactly one ready is high per cycle; none if no request.
  - last_grant updates on every transfer.
- Output stage: a granted request is registered. rf_write_o/rf_rd_o/rf_data_o are valid in cycle N+1 for a transfer in cycle N (latency 1). rf_write_o is a single-cycle pulse unless back-to-back transfers occur. Throughput: 1 write/cycle.
- x0: a request with rd=0 is accepted (ready=1, pointer updates), but rf_write_o stays 0 next cycle.
- Scoreboard: busy[r] sets at the edge where issue_valid_i=1 and issue_rd_i=r!=0. busy[r] clears at the edge where rf_write_o=1 and rf_rd_o=r. The same edge commits the register file write, so a read in the following cycle sees the new value.
- Simultaneous set and clear on the same r: set wins (a newer producer exists).
- busy[0] is always 0.
- stall_o (combinational) = busy[rs1_i] | busy[rs2_i] | (issue_valid_i & busy[issue_rd_i]). Index 0 never stalls.
- issue_valid_i while stall_o=1 is a protocol error; the scoreboard still sets, and the bench asserts this never happens.
- Reset mid-operation: a pending registered write is dropped and all busy bits are cleared. Upstream units are reset by the same rst_n.

Decomposition:
- Package rv_pkg holds:
  - XLEN, REG_AW, NUM_REGS
  - REG_X0 = 0
  - requester encoding constants: REQ_ALU=0, REQ_LSU=1
- Sub-module rv_rr_arb2:
  - 2-way round-robin arbiter: req[1:0] → gnt[1:0] one-hot.
  - Holds the last_grant flop, updated on "accept".
- Top level holds the output register, the x0 filter and the scoreboard.

Test Plan:
1. Reset then idle: rst_n low mid-cycle → rf_write_o=0 and busy_o=0 immediately (async), with no clock needed.
2. Single ALU write: alu_valid_i=1, alu_rd_i=5, alu_data_i=0xDEADBEEF → alu_ready_o=1 in cycle N; in cycle N+1 rf_write_o=1, rf_rd_o=5, rf_data_o=0xDEADBEEF; in N+2 rf_write_o=0.
3. Contention: both valid for 4 cycles (rd 1/2) → grants ALU, LSU, ALU, LSU; rf_rd_o sequence 1,2,1,2 one cycle later.
4. x0 drop: lsu_valid_i=1, lsu_rd_i=0, data=0x1234 → lsu_ready_o=1; next cycle rf_write_o=0; next tie goes to ALU.
5. Scoreboard: issue rd=7 → busy_o[7]=1 next cycle; rs1_i=7 gives stall_o=1; ALU writes rd=7 → stall_o=0 the cycle after rf_write_o pulses. Issue rd=7 on the same edge as the rd=7 commit → busy_o[7] remains 1.
6. Issue rd=0 → busy_o stays 0 and stall_o=0 for rs1_i=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared widths, requester encoding and writeback payload type for the
// register-file writeback path.
package rv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 2 ** REG_AW;

  localparam logic [REG_AW-1:0] REG_X0 = '0;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LSU = 1;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
    reg_onehot = NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/rv_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module rv_rr_arb2
  import rv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt_c
);

  // 1 means the LSU held the last grant; reset value lets the ALU win the first tie
  logic last_lsu_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_lsu_q <= 1'(REQ_LSU);
    end else if (accept) begin
      last_lsu_q <= gnt_c[REQ_LSU];
    end
  end

  always_comb begin
    gnt_c = '0;
    case (req)
      2'b01:   gnt_c[REQ_ALU] = 1'b1;
      2'b10:   gnt_c[REQ_LSU] = 1'b1;
      2'b11: begin
        if (last_lsu_q) gnt_c[REQ_ALU] = 1'b1;
        else            gnt_c[REQ_LSU] = 1'b1;
      end
      default: gnt_c = '0;
    endcase
  end

endmodule

// File: rtl/rv_wb_arbiter.sv
// Writeback controller: arbitrates ALU/LSU onto the single register-file write
// port and tracks pending destinations in a busy scoreboard for decode stalls.
module rv_wb_arbiter
  import rv_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid_i,
  input  logic [REG_AW-1:0]   alu_rd_i,
  input  logic [XLEN-1:0]     alu_data_i,
  output logic                alu_ready_o,
  input  logic                lsu_valid_i,
  input  logic [REG_AW-1:0]   lsu_rd_i,
  input  logic [XLEN-1:0]     lsu_data_i,
  output logic                lsu_ready_o,
  input  logic                issue_valid_i,
  input  logic [REG_AW-1:0]   issue_rd_i,
  input  logic [REG_AW-1:0]   rs1_i,
  input  logic [REG_AW-1:0]   rs2_i,
  output logic                stall_o,
  output logic                rf_write_o,
  output logic [REG_AW-1:0]   rf_rd_o,
  output logic [XLEN-1:0]     rf_data_o,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [1:0]          req;
  logic [1:0]          gnt;
  logic                xfer;
  wb_req_t             alu_req;
  wb_req_t             lsu_req;
  wb_req_t             sel_req;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] busy_set;
  logic [NUM_REGS-1:0] busy_clr;

  assign req     = {lsu_valid_i, alu_valid_i};
  assign xfer    = |gnt;
  assign alu_req = '{rd: alu_rd_i, data: alu_data_i};
  assign lsu_req = '{rd: lsu_rd_i, data: lsu_data_i};
  assign sel_req = gnt[REQ_LSU] ? lsu_req : alu_req;

  assign alu_ready_o = gnt[REQ_ALU];
  assign lsu_ready_o = gnt[REQ_LSU];

  rv_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .accept (xfer),
    .gnt_c  (gnt)
  );

  // Output stage; x0 writes are accepted but never reach the register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write_o <= 1'b0;
      rf_rd_o    <= '0;
      rf_data_o  <= '0;
      busy_q     <= '0;
    end else begin
      rf_write_o <= xfer && (sel_req.rd != REG_X0);
      if (xfer) begin
        rf_rd_o   <= sel_req.rd;
        rf_data_o <= sel_req.data;
      end
      busy_q <= busy_d;
    end
  end

  // A new producer issued on the committing edge keeps its register busy
  always_comb begin
    busy_clr = rf_write_o ? reg_onehot(rf_rd_o) : '0;
    busy_set = (issue_valid_i && (issue_rd_i != REG_X0)) ? reg_onehot(issue_rd_i) : '0;
    busy_d   = (busy_q & ~busy_clr) | busy_set;
    busy_d[REG_X0] = 1'b0;
  end

  assign busy_o  = busy_q;
  assign stall_o = busy_q[rs1_i] | busy_q[rs2_i] | (issue_valid_i & busy_q[issue_rd_i]);

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Directed self-checking bench for rv_wb_arbiter.
module tb_rv_wb_arbiter;
  import rv_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                alu_valid_i, lsu_valid_i, issue_valid_i;
  logic [REG_AW-1:0]   alu_rd_i, lsu_rd_i, issue_rd_i, rs1_i, rs2_i;
  logic [XLEN-1:0]     alu_data_i, lsu_data_i;
  logic                alu_ready_o, lsu_ready_o, stall_o, rf_write_o;
  logic [REG_AW-1:0]   rf_rd_o;
  logic [XLEN-1:0]     rf_data_o;
  logic [NUM_REGS-1:0] busy_o;

  int checks   = 0;
  int failures = 0;
  logic allow_waw = 1'b0;

  rv_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready_o),
    .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i), .lsu_ready_o(lsu_ready_o),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .stall_o(stall_o), .rf_write_o(rf_write_o), .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Decode must never issue into a stall, except the one deliberate WAW-on-commit case
  always @(negedge clk) begin
    if (rst_n && issue_valid_i && !allow_waw) begin
      checks++;
      if (stall_o !== 1'b0) begin
        failures++;
        $display("FAIL issue_during_stall: stall_o=%b required 0 (issue_rd=%0d)", stall_o, issue_rd_i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid_i = 0; lsu_valid_i = 0; issue_valid_i = 0;
    alu_rd_i = '0; lsu_rd_i = '0; issue_rd_i = '0; rs1_i = '0; rs2_i = '0;
    alu_data_i = '0; lsu_data_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    // Put a write in flight and a busy bit up, then reset mid-cycle
    issue_valid_i = 1; issue_rd_i = 5'd3;
    alu_valid_i = 1; alu_rd_i = 5'd4; alu_data_i = 32'h5555_AAAA;
    step();
    idle_inputs();
    #1;
    checks++;
    if (rf_write_o !== 1'b1 || busy_o[3] !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre: rf_write=%b busy3=%b required 1 1", rf_write_o, busy_o[3]);
    end
    #1 rst_n = 0;
    #1;
    checks++;
    if (rf_write_o !== 1'b0 || busy_o !== '0 || rf_rd_o !== '0 || rf_data_o !== '0) begin
      failures++;
      $display("FAIL reset_async: rf_write=%b busy=%h rd=%0d data=%h required 0 0 0 0",
               rf_write_o, busy_o, rf_rd_o, rf_data_o);
    end
    checks++;
    if (alu_ready_o !== 1'b0 || lsu_ready_o !== 1'b0 || stall_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_ready: alu_rdy=%b lsu_rdy=%b stall=%b required 0 0 0",
               alu_ready_o, lsu_ready_o, stall_o);
    end
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_single_alu();
    alu_valid_i = 1; alu_rd_i = 5'd5; alu_data_i = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (alu_ready_o !== 1'b1 || lsu_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL single_ready: alu_rdy=%b lsu_rdy=%b required 1 0", alu_ready_o, lsu_ready_o);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (rf_write_o !== 1'b1 || rf_rd_o !== 5'd5 || rf_data_o !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL single_write: we=%b rd=%0d data=%h required 1 5 deadbeef", rf_write_o, rf_rd_o, rf_data_o);
    end
    step();
    checks++;
    if (rf_write_o !== 1'b0) begin
      failures++;
      $display("FAIL single_pulse: we=%b required 0", rf_write_o);
    end
  endtask

  task automatic test_contention();
    logic [1:0]        exp_gnt [4];
    logic [REG_AW-1:0] exp_rd  [4];
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_rd  = '{5'd1, 5'd2, 5'd1, 5'd2};
    do_reset();
    alu_valid_i = 1; alu_rd_i = 5'd1; alu_data_i = 32'h0000_00A1;
    lsu_valid_i = 1; lsu_rd_i = 5'd2; lsu_data_i = 32'h0000_00B2;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) idle_inputs();
      #1;
      if (k < 4) begin
        checks++;
        if ({lsu_ready_o, alu_ready_o} !== exp_gnt[k]) begin
          failures++;
          $display("FAIL contention_gnt[%0d]: lsu/alu ready=%b required %b", k, {lsu_ready_o, alu_ready_o}, exp_gnt[k]);
        end
      end
      if (k > 0) begin
        checks++;
        if (rf_write_o !== 1'b1 || rf_rd_o !== exp_rd[k-1] ||
            rf_data_o !== ((exp_rd[k-1] == 5'd1) ? 32'h0000_00A1 : 32'h0000_00B2)) begin
          failures++;
          $display("FAIL contention_rd[%0d]: we=%b rd=%0d data=%h required 1 %0d", k, rf_write_o, rf_rd_o, rf_data_o, exp_rd[k-1]);
        end
      end
      step();
    end
  endtask

  task automatic test_x0_drop();
    lsu_valid_i = 1; lsu_rd_i = REG_X0; lsu_data_i = 32'h0000_1234;
    #1;
    checks++;
    if (lsu_ready_o !== 1'b1 || alu_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL x0_ready: lsu_rdy=%b alu_rdy=%b required 1 0", lsu_ready_o, alu_ready_o);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (rf_write_o !== 1'b0) begin
      failures++;
      $display("FAIL x0_no_write: we=%b required 0", rf_write_o);
    end
    alu_valid_i = 1; alu_rd_i = 5'd9; alu_data_i = 32'h99;
    lsu_valid_i = 1; lsu_rd_i = 5'd10; lsu_data_i = 32'hAA;
    #1;
    checks++;
    if (alu_ready_o !== 1'b1 || lsu_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL x0_next_tie: alu_rdy=%b lsu_rdy=%b required 1 0", alu_ready_o, lsu_ready_o);
    end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_scoreboard();
    issue_valid_i = 1; issue_rd_i = 5'd7;
    step();
    issue_valid_i = 0; rs1_i = 5'd7;
    #1;
    checks++;
    if (busy_o[7] !== 1'b1 || stall_o !== 1'b1) begin
      failures++;
      $display("FAIL sb_set: busy7=%b stall=%b required 1 1", busy_o[7], stall_o);
    end
    alu_valid_i = 1; alu_rd_i = 5'd7; alu_data_i = 32'h7777_0007;
    step();
    alu_valid_i = 0;
    #1;
    checks++;
    if (rf_write_o !== 1'b1 || rf_rd_o !== 5'd7 || stall_o !== 1'b1) begin
      failures++;
      $display("FAIL sb_commit: we=%b rd=%0d stall=%b required 1 7 1", rf_write_o, rf_rd_o, stall_o);
    end
    step();
    checks++;
    if (stall_o !== 1'b0 || busy_o[7] !== 1'b0) begin
      failures++;
      $display("FAIL sb_clear: stall=%b busy7=%b required 0 0", stall_o, busy_o[7]);
    end
    // New producer issued on the same edge the older write to r7 commits
    rs1_i = '0;
    issue_valid_i = 1; issue_rd_i = 5'd7;
    step();
    issue_valid_i = 0;
    alu_valid_i = 1; alu_rd_i = 5'd7; alu_data_i = 32'h7;
    step();
    alu_valid_i = 0;
    allow_waw = 1;
    issue_valid_i = 1; issue_rd_i = 5'd7;
    #1;
    checks++;
    if (rf_write_o !== 1'b1 || rf_rd_o !== 5'd7) begin
      failures++;
      $display("FAIL sb_waw_commit: we=%b rd=%0d required 1 7", rf_write_o, rf_rd_o);
    end
    step();
    issue_valid_i = 0;
    allow_waw = 0;
    checks++;
    if (busy_o[7] !== 1'b1) begin
      failures++;
      $display("FAIL sb_set_wins: busy7=%b required 1", busy_o[7]);
    end
    alu_valid_i = 1; alu_rd_i = 5'd7; alu_data_i = 32'h8;
    step();
    alu_valid_i = 0;
    step();
    checks++;
    if (busy_o !== '0) begin
      failures++;
      $display("FAIL sb_drain: busy=%h required 0", busy_o);
    end
  endtask

  task automatic test_x0_issue();
    issue_valid_i = 1; issue_rd_i = REG_X0; rs1_i = REG_X0; rs2_i = REG_X0;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      failures++;
      $display("FAIL x0_issue_stall: stall=%b required 0", stall_o);
    end
    step();
    issue_valid_i = 0;
    #1;
    checks++;
    if (busy_o !== '0 || stall_o !== 1'b0) begin
      failures++;
      $display("FAIL x0_issue_busy: busy=%h stall=%b required 0 0", busy_o, stall_o);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1;
    test_reset();
    test_single_alu();
    test_contention();
    test_x0_drop();
    test_scoreboard();
    test_x0_issue();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
